regdump_ctrl: RTL and testbench



---
 rtl/regdump_ctrl.sv | 168 ++++++++++++++++
 tb/tb_regdump_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regdump_ctrl.sv
// regdump_ctrl: drains the DLX pipeline with NOPs, then forces one ADDI per register and streams each busA value.
// Build option: define REGDUMP_SKIP_R0_EN to skip r0 (dump r1..r31 only).
module regdump_ctrl #(
    parameter int          DRAIN_CYCLES = 5,
    parameter int          READ_LAT     = 1,
    parameter logic [5:0]  DUMP_OPCODE  = 6'b001000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] busA_probe,
    output logic        override_inst,
    output logic [31:0] force_inst,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [4:0]  dump_idx,
    output logic [31:0] dump_data,
    output logic        busy,
    output logic        done
);

    localparam int CW = 16;

`ifdef REGDUMP_SKIP_R0_EN
    localparam logic [4:0] FIRST_IDX = 5'd1;
`else
    localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ISSUE,
        S_OUT,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     idx_q, idx_d;
    logic           override_q, override_d;
    logic [31:0]    force_q, force_d;
    logic           valid_q, valid_d;
    logic [4:0]     didx_q, didx_d;
    logic [31:0]    ddata_q, ddata_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // rs1 = idx puts the register on busA; rd = r0 makes write-back a no-op
    function automatic logic [31:0] read_word(input logic [4:0] i);
        return {DUMP_OPCODE, i, 5'b00000, 16'h0000};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        force_d = force_q;
        valid_d = valid_q;
        didx_d  = didx_q;
        ddata_d = ddata_q;
        unique case (state_q)
            S_IDLE: begin
                idx_d   = FIRST_IDX;
                cnt_d   = '0;
                force_d = '0;
                valid_d = 1'b0;
                didx_d  = '0;
                ddata_d = '0;
                if (start) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = S_ISSUE;
                        cnt_d   = CW'(READ_LAT);
                        force_d = read_word(FIRST_IDX);
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = CW'(DRAIN_CYCLES);
                    end
                end
            end
            S_DRAIN: begin
                force_d = '0;
                if (cnt_q <= CW'(1)) begin
                    state_d = S_ISSUE;
                    cnt_d   = CW'(READ_LAT);
                    force_d = read_word(idx_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_ISSUE: begin
                if (cnt_q <= CW'(1)) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    didx_d  = idx_q;
                    ddata_d = busA_probe;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OUT: begin
                if (dump_ready) begin
                    valid_d = 1'b0;
                    // idx never wraps: r31 always ends the dump
                    if (idx_q == 5'd31) begin
                        state_d = S_DONE;
                        force_d = '0;
                    end else begin
                        state_d = S_ISSUE;
                        idx_d   = idx_q + 5'd1;
                        cnt_d   = CW'(READ_LAT);
                        force_d = read_word(idx_q + 5'd1);
                    end
                end
            end
            S_DONE: begin
                force_d = '0;
                if (!start) begin
                    state_d = S_IDLE;
                    didx_d  = '0;
                    ddata_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        override_d = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            override_q <= 1'b0;
            force_q    <= '0;
            valid_q    <= 1'b0;
            didx_q     <= '0;
            ddata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            override_q <= override_d;
            force_q    <= force_d;
            valid_q    <= valid_d;
            didx_q     <= didx_d;
            ddata_q    <= ddata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign override_inst = override_q;
    assign force_inst    = force_q;
    assign dump_valid    = valid_q;
    assign dump_idx      = didx_q;
    assign dump_data     = ddata_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_regdump_ctrl.sv
// Scoreboard bench for regdump_ctrl: default instance plus a READ_LAT=3, DRAIN_CYCLES=0 instance.
module tb_regdump_ctrl;

`ifdef REGDUMP_SKIP_R0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NB   = 32 - FIRST;
    localparam int DR_A = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, ready_a = 1'b1;
    logic [31:0] bus_a, force_a, data_a;
    logic        ovr_a, valid_a, busy_a, done_a;
    logic [4:0]  idx_a;

    logic        start_b = 1'b0, ready_b = 1'b1;
    logic [31:0] bus_b, force_b, data_b;
    logic        ovr_b, valid_b, busy_b, done_b;
    logic [4:0]  idx_b;
    logic [31:0] hb1 = '0, hb2 = '0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [36:0] qa[$];
    logic [36:0] qb[$];
    bit stall_en = 1'b0;

    regdump_ctrl u_a (
        .clk(clk), .reset(reset), .start(start_a),
        .busA_probe(bus_a), .override_inst(ovr_a),
        .force_inst(force_a), .dump_valid(valid_a),
        .dump_ready(ready_a), .dump_idx(idx_a),
        .dump_data(data_a), .busy(busy_a), .done(done_a)
    );

    regdump_ctrl #(.DRAIN_CYCLES(0), .READ_LAT(3)) u_b (
        .clk(clk), .reset(reset), .start(start_b),
        .busA_probe(bus_b), .override_inst(ovr_b),
        .force_inst(force_b), .dump_valid(valid_b),
        .dump_ready(ready_b), .dump_idx(idx_b),
        .dump_data(data_b), .busy(busy_b), .done(done_b)
    );

    function automatic logic [31:0] rf(input logic [4:0] i);
        return 32'hA500_0000 + {27'd0, i};
    endfunction

    function automatic logic [31:0] rw(input logic [4:0] i);
        return {6'b001000, i, 5'd0, 16'h0000};
    endfunction

    // Register-file model: combinational at latency 1, two flops deep at latency 3
    assign bus_a = rf(force_a[25:21]);
    assign bus_b = rf(hb2[25:21]);
    always @(posedge clk) begin
        hb1 <= force_b;
        hb2 <= hb1;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_a();
        for (int i = FIRST; i < 32; i++)
            qa.push_back({i[4:0], rf(i[4:0])});
    endtask

    task automatic push_b();
        for (int i = FIRST; i < 32; i++)
            qb.push_back({i[4:0], rf(i[4:0])});
    endtask

    // Monitor A: beat order/content, hold-under-stall, override at capture
    initial begin
        logic        pv, pr;
        logic [4:0]  pidx;
        logic [31:0] pdata;
        logic [36:0] e;
        pv = 0; pr = 0; pidx = 0; pdata = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0;
            end else begin
                if (valid_a && !pv)
                    check("ovr_at_cap_a", ovr_a, 1);
                if (pv && !pr)
                    check("stall_hold_a", {valid_a, idx_a, data_a},
                          {1'b1, pidx, pdata});
                if (valid_a && ready_a) begin
                    if (qa.size() == 0) begin
                        check("extra_beat_a", {idx_a, data_a}, 0);
                    end else begin
                        e = qa.pop_front();
                        check("beat_a", {idx_a, data_a}, e);
                    end
                end
                pv = valid_a; pr = ready_a;
                pidx = idx_a; pdata = data_a;
            end
        end
    end

    // Monitor B: beats plus how long each read word is held before capture
    initial begin
        logic        pv;
        logic [31:0] pf;
        int          hold;
        logic [36:0] e;
        pv = 0; pf = 0; hold = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pv = 0; pf = 0; hold = 0;
            end else begin
                if (!valid_b && ovr_b && force_b != 0)
                    hold = (force_b == pf) ? hold + 1 : 1;
                pf = force_b;
                if (valid_b && !pv) begin
                    check("ovr_at_cap_b", ovr_b, 1);
                    check("hold_b", hold, 3);
                end
                if (valid_b && ready_b) begin
                    if (qb.size() == 0) begin
                        check("extra_beat_b", {idx_b, data_b}, 0);
                    end else begin
                        e = qb.pop_front();
                        check("beat_b", {idx_b, data_b}, e);
                    end
                end
                pv = valid_b;
            end
        end
    end

    // Backpressure driver: hold ready low for 10 cycles once beat 7 shows
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall_en && valid_a && idx_a == 5'd7) begin
                ready_a = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                ready_a = 1'b1;
                stall_en = 1'b0;
            end
        end
    end

    task automatic run_a(input bit hold, input int exp_cyc);
        int cyc;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        if (!hold) start_a = 1'b0;
        cyc = 0;
        while (!done_a && cyc < 3000) begin
            if (cyc < DR_A) begin
                check("drain_ovr", ovr_a, 1);
                check("drain_nop", force_a, 0);
            end else if (cyc == DR_A) begin
                check("first_word", force_a, rw(5'(FIRST)));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("done_lat_a", cyc, exp_cyc);
    endtask

    task automatic idle_after_done();
        @(posedge clk); #1;
        check("idle_ovr", ovr_a, 0);
        check("idle_busy", {busy_a, done_a}, 0);
        check("q_empty_a", qa.size(), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ovr", ovr_a, 0);
        check("rst_force", force_a, 0);
        check("rst_out", {valid_a, idx_a, data_a}, 0);
        check("rst_flags", {busy_a, done_a}, 0);
        check("rst_b", {ovr_b, valid_b, busy_b, done_b}, 0);
        reset = 1'b0;

        // basic dump, ready tied high
        push_a();
        run_a(0, DR_A + 2 * NB);
        idle_after_done();

        // backpressure at beat 7
        push_a();
        stall_en = 1'b1;
        run_a(0, DR_A + 2 * NB + 10);
        idle_after_done();

        // reset while beat 12 is presented
        push_a();
        @(negedge clk); start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        cyc = 0;
        while (!(valid_a && idx_a == 5'd12) && cyc < 500) begin
            @(posedge clk); #1; cyc++;
        end
        check("reach_b12", cyc < 500, 1);
        ready_a = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mrst_ovr", ovr_a, 0);
        check("mrst_valid", valid_a, 0);
        check("mrst_busy", busy_a, 0);
        reset = 1'b0;
        ready_a = 1'b1;
        qa.delete();
        push_a();
        run_a(0, DR_A + 2 * NB);
        idle_after_done();

        // start held high: one dump, done sticks until start drops
        push_a();
        run_a(1, DR_A + 2 * NB);
        repeat (5) begin
            @(posedge clk); #1;
            check("done_hold", {done_a, busy_a, ovr_a}, 3'b111);
            check("done_nop", force_a, 0);
        end
        start_a = 1'b0;
        idle_after_done();
        repeat (10) @(posedge clk);
        #1;
        check("no_redump", {valid_a, busy_a}, 0);

        // start pulse during ISSUE is ignored
        push_a();
        fork
            run_a(0, DR_A + 2 * NB);
            begin
                int c;
                c = 0;
                do begin
                    @(posedge clk); #1; c++;
                end while (!(valid_a && idx_a == 5'd3) && c < 500);
                @(posedge clk); #1;
                check("in_issue", {valid_a, ovr_a}, 2'b01);
                start_a = 1'b1;
                @(posedge clk); #1;
                start_a = 1'b0;
            end
        join
        idle_after_done();

        // READ_LAT=3, no drain
        push_b();
        @(negedge clk); start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        check("b_first_word", force_b, rw(5'(FIRST)));
        check("b_first_ovr", ovr_b, 1);
        cyc = 0;
        while (!done_b && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        check("done_lat_b", cyc, 4 * NB);
        @(posedge clk); #1;
        check("b_idle", {ovr_b, busy_b}, 0);
        check("q_empty_b", qb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
